// File: rtl/pipe_pkg.sv
// Shared types for the RAT core pipeline: hazard FSM states, register address width,
// control-vector field layout.
package pipe_pkg;

   localparam int REG_AW_DEF = 5;

   typedef enum logic [1:0] {
      HZ_RUN   = 2'd0,
      HZ_FLUSH = 2'd1,
      HZ_STALL = 2'd2
   } hz_state_t;

   // Subset of the control vector that the hazard controller observes in EX.
   typedef struct packed {
      logic pc_ld;
      logic rf_wr;
      logic scr_rd;
   } ctrl_vec_t;

   function automatic logic [3:0] cnt_load(input int n);
      return 4'(n - 1);
   endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use operand comparator: flags an ID source that matches a late-result EX destination.
// Purely combinational; all REG_AW bits compared, no zero-register exemption.
module hazard_cmp
   import pipe_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              ex_rf_wr,
   input  logic              ex_scr_rd,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_vld,
   input  logic              id_rt_vld,
   output logic              hit
);

   logic rs_match;
   logic rt_match;

   assign rs_match = id_rs_vld && (id_rs == ex_rd);
   assign rt_match = id_rt_vld && (id_rt == ex_rd);
   assign hit      = ex_rf_wr && ex_scr_rd && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Branch flush / load-use stall controller; zero-cycle Mealy response in RUN, state-driven otherwise.
// Optional HAZARD_STATS_EN adds saturating stall_cycles/flush_cycles counters.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int LOAD_LAT     = 1,
   parameter int REG_AW       = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_PC_LD,
   input  logic              ex_RF_WR,
   input  logic              ex_SCR_RD,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_vld,
   input  logic              id_rt_vld,
   output logic              pc_hold,
   output logic              id_hold,
   output logic              id_nop,
   output logic              ex_nop,
   output logic              busy
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0]       stall_cycles,
   output logic [15:0]       flush_cycles
`endif
);

   localparam logic [3:0] FLUSH_INIT = cnt_load(FLUSH_CYCLES);
   localparam logic [3:0] STALL_INIT = cnt_load(LOAD_LAT);

   hz_state_t  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       hit;
   logic       hold_c, flush_c;

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_q, stall_d;
   logic [15:0] flush_q, flush_d;
`endif

   hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
      .ex_rf_wr  (ex_RF_WR),
      .ex_scr_rd (ex_SCR_RD),
      .ex_rd     (ex_rd),
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_rs_vld (id_rs_vld),
      .id_rt_vld (id_rt_vld),
      .hit       (hit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_c  = 1'b0;
      flush_c = 1'b0;
      case (state_q)
         HZ_RUN: begin
            if (ex_PC_LD) begin
               flush_c = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d = HZ_FLUSH;
                  cnt_d   = FLUSH_INIT;
               end
            end else if (hit) begin
               hold_c = 1'b1;
               if (LOAD_LAT > 1) begin
                  state_d = HZ_STALL;
                  cnt_d   = STALL_INIT;
               end
            end
         end
         HZ_FLUSH: begin
            // EX already carries a bubble here, so branch/hit inputs are meaningless.
            flush_c = 1'b1;
            cnt_d   = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = HZ_RUN;
         end
         HZ_STALL: begin
            if (ex_PC_LD) begin
               flush_c = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d = HZ_FLUSH;
                  cnt_d   = FLUSH_INIT;
               end else begin
                  state_d = HZ_RUN;
                  cnt_d   = 4'd0;
               end
            end else begin
               hold_c = 1'b1;
               cnt_d  = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = HZ_RUN;
            end
         end
         default: begin
            state_d = HZ_RUN;
            cnt_d   = 4'd0;
         end
      endcase
`ifdef HAZARD_STATS_EN
      stall_d = stall_q;
      flush_d = flush_q;
      if (hold_c && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
      if (flush_c && (flush_q != 16'hFFFF)) flush_d = flush_q + 16'd1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HZ_RUN;
         cnt_q   <= 4'd0;
`ifdef HAZARD_STATS_EN
         stall_q <= 16'd0;
         flush_q <= 16'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef HAZARD_STATS_EN
         stall_q <= stall_d;
         flush_q <= flush_d;
`endif
      end
   end

   // Reset gates the outputs combinationally so inputs cannot leak through during rst_n=0.
   assign pc_hold = rst_n & hold_c;
   assign id_hold = rst_n & hold_c;
   assign id_nop  = rst_n & flush_c;
   assign ex_nop  = rst_n & (hold_c | flush_c);
   assign busy    = rst_n & (state_q != HZ_RUN);

`ifdef HAZARD_STATS_EN
   assign stall_cycles = stall_q;
   assign flush_cycles = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a bubble/hold budget model.
// Two instances: defaults (FLUSH_CYCLES=2, LOAD_LAT=1) and FLUSH_CYCLES=3, LOAD_LAT=3.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rst_req;
   logic       pc_ld, rf_wr, scr_rd, rs_vld, rt_vld;
   logic [4:0] ex_rd, id_rs, id_rt;

   logic       d0_pc_hold, d0_id_hold, d0_id_nop, d0_ex_nop, d0_busy;
   logic       d3_pc_hold, d3_id_hold, d3_id_nop, d3_ex_nop, d3_busy;
`ifdef HAZARD_STATS_EN
   logic [15:0] d0_stall, d0_flush, d3_stall, d3_flush;
   int          m_stall [2];
   int          m_flush [2];
`endif

   int n_chk = 0;
   int n_err = 0;

   // Model: bubbles/holds still owed, counting the current cycle onward from the next edge.
   int fl_left [2];
   int hl_left [2];
   int fl_par  [2] = '{2, 3};
   int ll_par  [2] = '{1, 3};
   int obs_nop [2];
   int obs_hold[2];

   logic [4:0] act [2];

   always #5 clk = ~clk;

   pipe_hazard_ctrl u_d0 (
      .clk(clk), .rst_n(rst_n), .ex_PC_LD(pc_ld), .ex_RF_WR(rf_wr), .ex_SCR_RD(scr_rd),
      .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(rs_vld), .id_rt_vld(rt_vld),
      .pc_hold(d0_pc_hold), .id_hold(d0_id_hold), .id_nop(d0_id_nop), .ex_nop(d0_ex_nop),
      .busy(d0_busy)
`ifdef HAZARD_STATS_EN
      , .stall_cycles(d0_stall), .flush_cycles(d0_flush)
`endif
   );

   pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .LOAD_LAT(3)) u_d3 (
      .clk(clk), .rst_n(rst_n), .ex_PC_LD(pc_ld), .ex_RF_WR(rf_wr), .ex_SCR_RD(scr_rd),
      .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(rs_vld), .id_rt_vld(rt_vld),
      .pc_hold(d3_pc_hold), .id_hold(d3_id_hold), .id_nop(d3_id_nop), .ex_nop(d3_ex_nop),
      .busy(d3_busy)
`ifdef HAZARD_STATS_EN
      , .stall_cycles(d3_stall), .flush_cycles(d3_flush)
`endif
   );

   assign act[0] = {d0_pc_hold, d0_id_hold, d0_id_nop, d0_ex_nop, d0_busy};
   assign act[1] = {d3_pc_hold, d3_id_hold, d3_id_nop, d3_ex_nop, d3_busy};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge with inputs applied: compare, then advance the model.
   task automatic tick(input string tag);
      logic hit;
      logic ph, nop, bsy;
      int   nf, nh;
      #2;
      hit = rf_wr && scr_rd && ((rs_vld && id_rs == ex_rd) || (rt_vld && id_rt == ex_rd));
      for (int k = 0; k < 2; k++) begin
         ph = 1'b0; nop = 1'b0;
         bsy = (fl_left[k] > 0) || (hl_left[k] > 0);
         nf = 0; nh = 0;
         if (!rst_n) begin
            bsy = 1'b0;
         end else if (fl_left[k] > 0) begin
            nop = 1'b1; nf = fl_left[k] - 1;
         end else if (pc_ld) begin
            nop = 1'b1; nf = fl_par[k] - 1;
         end else if (hl_left[k] > 0) begin
            ph = 1'b1; nh = hl_left[k] - 1;
         end else if (hit) begin
            ph = 1'b1; nh = ll_par[k] - 1;
         end
         chk($sformatf("%s.d%0d.outs", tag, k), 32'(act[k]), 32'({ph, ph, nop, ph | nop, bsy}));
         chk($sformatf("%s.d%0d.excl", tag, k), 32'(act[k][4] & act[k][2]), 32'd0);
`ifdef HAZARD_STATS_EN
         chk($sformatf("%s.d%0d.stall", tag, k), 32'(k == 0 ? d0_stall : d3_stall), 32'(m_stall[k]));
         chk($sformatf("%s.d%0d.flush", tag, k), 32'(k == 0 ? d0_flush : d3_flush), 32'(m_flush[k]));
         if (!rst_n) begin
            m_stall[k] = 0; m_flush[k] = 0;
         end else begin
            if (ph && m_stall[k] < 65535) m_stall[k]++;
            if (nop && m_flush[k] < 65535) m_flush[k]++;
         end
`endif
         if (act[k][2]) obs_nop[k]++;
         if (act[k][4]) obs_hold[k]++;
         fl_left[k] = nf;
         hl_left[k] = nh;
      end
   endtask

   task automatic drive(input string tag, input logic p, input logic w, input logic s,
                        input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsv, input logic rtv);
      @(negedge clk);
      rst_n = rst_req;
      pc_ld = p; rf_wr = w; scr_rd = s; ex_rd = rd; id_rs = rs; id_rt = rt;
      rs_vld = rsv; rt_vld = rtv;
      tick(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) drive(tag, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
   endtask

   task automatic clr_obs();
      for (int k = 0; k < 2; k++) begin
         obs_nop[k] = 0; obs_hold[k] = 0;
      end
   endtask

   initial begin
      rst_n = 1'b0; rst_req = 1'b0;
      pc_ld = 0; rf_wr = 0; scr_rd = 0; ex_rd = 0; id_rs = 0; id_rt = 0; rs_vld = 0; rt_vld = 0;
      for (int k = 0; k < 2; k++) begin
         fl_left[k] = 0; hl_left[k] = 0;
`ifdef HAZARD_STATS_EN
         m_stall[k] = 0; m_flush[k] = 0;
`endif
      end
      clr_obs();

      // Reset holds outputs low even with branch and hazard inputs active.
      drive("rst", 1, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1);
      chk("rst_outs_d0", 32'(act[0]), 32'd0);
      chk("rst_outs_d3", 32'(act[1]), 32'd0);
      rst_req = 1'b1;
      idle("rel", 3);

      clr_obs();
      drive("br", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      idle("br", 4);
      chk("br_bubbles_d0", 32'(obs_nop[0]), 32'd2);
      chk("br_bubbles_d3", 32'(obs_nop[1]), 32'd3);
      chk("br_holds_d0", 32'(obs_hold[0]), 32'd0);

      clr_obs();
      drive("lu", 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0);
      idle("lu", 4);
      chk("lu_holds_d0", 32'(obs_hold[0]), 32'd1);
      chk("lu_holds_d3", 32'(obs_hold[1]), 32'd3);

      clr_obs();
      drive("lu_novld", 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0);
      idle("lu_novld", 2);
      chk("lu_novld_holds", 32'(obs_hold[0] + obs_hold[1]), 32'd0);

      clr_obs();
      drive("brhit", 1, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1);
      idle("brhit", 4);
      chk("brhit_hold_d0", 32'(obs_hold[0]), 32'd0);
      chk("brhit_nop_d0", 32'(obs_nop[0]), 32'd2);
      chk("brhit_nop_d3", 32'(obs_nop[1]), 32'd3);

      // Branch lands on the second stall cycle of the LOAD_LAT=3 instance.
      clr_obs();
      drive("brstall", 0, 1, 1, 5'd7, 5'd0, 5'd7, 0, 1);
      drive("brstall", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      idle("brstall", 5);
      chk("brstall_hold_d3", 32'(obs_hold[1]), 32'd1);
      chk("brstall_nop_d3", 32'(obs_nop[1]), 32'd3);
      chk("brstall_busy_d3", 32'(d3_busy), 32'd0);

      drive("midflush", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      rst_req = 1'b0;
      drive("midflush_rst", 1, 1, 1, 5'd3, 5'd3, 5'd3, 1, 1);
      chk("midflush_rst_d3", 32'(act[1]), 32'd0);
      rst_req = 1'b1;
      idle("midflush_rel", 1);
      chk("midflush_busy_d0", 32'(d0_busy), 32'd0);
      chk("midflush_busy_d3", 32'(d3_busy), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         rst_req = ($urandom_range(0, 199) != 0);
         drive("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3) | ($urandom_range(0, 15) == 0 ? 16 : 0)),
               5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end
      rst_req = 1'b1;
      idle("rand_end", 4);

`ifdef HAZARD_STATS_EN
      rst_req = 1'b0;
      idle("st_rst", 1);
      rst_req = 1'b1;
      for (int b = 0; b < 3; b++) begin
         drive("st_br", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
         idle("st_br", 3);
      end
      for (int l = 0; l < 2; l++) begin
         drive("st_lu", 0, 1, 1, 5'd4, 5'd4, 5'd0, 1, 0);
         idle("st_lu", 4);
      end
      chk("stats_flush_d0", 32'(d0_flush), 32'd6);
      chk("stats_stall_d0", 32'(d0_stall), 32'd2);
      for (int i = 0; i < 70000; i++) drive("st_sat", 0, 1, 1, 5'd9, 5'd9, 5'd9, 1, 1);
      idle("st_sat", 1);
      chk("stats_sat_d0", 32'(d0_stall), 32'd65535);
      chk("stats_sat_d3", 32'(d3_stall), 32'd65535);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
